// File: rtl/wb_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : wb_stage
//  Purpose  : Write-back stage of the five-stage MIPS core. Accepts retiring
//             instructions from the memory stage over a valid/ready handshake,
//             waits for load data from the AXI bridge read-response channel,
//             extracts and extends byte/halfword loads, and drives the
//             register file write port for exactly one cycle per instruction.
//             The destination of an in-flight load is exported so decode can
//             interlock on it.
//
//  Ports    : cpu_clk_50M, cpu_rst          clock, synchronous active-high reset
//             in_valid/in_ready             retiring-instruction handshake
//             in_pc, in_wa, in_we, in_res   instruction payload
//             in_ld, in_ld_size, in_ld_sext load attributes
//             dresp_valid/dresp_data/dresp_ready  load-data response
//             wa, wd, we                    register file write port (registered)
//             pend_valid, pend_wa           pending-write hazard export
//             debug_wb_*                    commit trace (WB_DEBUG_TRACE_EN only)
//
//  Config   : WB_DEBUG_TRACE_EN - when defined, adds the registered commit
//             trace outputs and a PC capture register.
//
//  Revision : 1.0 - initial release
// ============================================================================
module wb_stage #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [RA_W-1:0]   in_wa,
    input  logic              in_we,
    input  logic [DATA_W-1:0] in_res,
    input  logic              in_ld,
    input  logic [1:0]        in_ld_size,
    input  logic              in_ld_sext,

    input  logic              dresp_valid,
    input  logic [DATA_W-1:0] dresp_data,
    output logic              dresp_ready,

    output logic [RA_W-1:0]   wa,
    output logic [DATA_W-1:0] wd,
    output logic              we,

    output logic              pend_valid,
    output logic [RA_W-1:0]   pend_wa
`ifdef WB_DEBUG_TRACE_EN
    ,
    output logic [31:0]       debug_wb_pc,
    output logic [3:0]        debug_wb_rf_wen,
    output logic [4:0]        debug_wb_rf_wnum,
    output logic [31:0]       debug_wb_rf_wdata
`endif
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_DATA = 2'd1,
        S_COMMIT    = 2'd2
    } state_t;

    localparam logic [1:0] c_SIZE_BYTE = 2'd0;
    localparam logic [1:0] c_SIZE_HALF = 2'd1;

    state_t            r_state;
    state_t            w_state_nxt;

    // Captured instruction attributes. r_wa doubles as the architectural
    // write address and the hazard-export destination.
    logic [RA_W-1:0]   r_wa;
    logic [DATA_W-1:0] r_wd;
    logic              r_we;
    logic              r_cap_we;
    logic [1:0]        r_off;
    logic [1:0]        r_ld_size;
    logic              r_ld_sext;

    logic              w_accept;
    logic              w_ld_done;

    logic [RA_W-1:0]   w_wa_nxt;
    logic [DATA_W-1:0] w_wd_nxt;
    logic              w_we_nxt;
    logic              w_cap_we_nxt;
    logic [1:0]        w_off_nxt;
    logic [1:0]        w_ld_size_nxt;
    logic              w_ld_sext_nxt;

    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_ld_data;

    // ------------------------------------------------------------------------
    // Handshake outputs depend only on state
    // ------------------------------------------------------------------------
    assign in_ready    = (r_state != S_WAIT_DATA);
    assign dresp_ready = (r_state == S_WAIT_DATA);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and transfer strobes
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_ld_done   = 1'b0;
        case (r_state)
            S_IDLE, S_COMMIT: begin
                // A response beat arriving here is neither consumed nor acted on.
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = in_ld ? S_WAIT_DATA : S_COMMIT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT_DATA: begin
                if (dresp_valid) begin
                    w_ld_done   = 1'b1;
                    w_state_nxt = S_COMMIT;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Load data extraction and extension
    // ------------------------------------------------------------------------
    always_comb begin
        w_byte    = dresp_data[8*r_off +: 8];
        // Halfword alignment is guaranteed upstream, so off[0] is ignored.
        w_half    = r_off[1] ? dresp_data[16 +: 16] : dresp_data[0 +: 16];
        w_ld_data = dresp_data;
        case (r_ld_size)
            c_SIZE_BYTE: w_ld_data = {{(DATA_W-8){r_ld_sext & w_byte[7]}}, w_byte};
            c_SIZE_HALF: w_ld_data = {{(DATA_W-16){r_ld_sext & w_half[15]}}, w_half};
            default:     w_ld_data = dresp_data;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath next values
    // ------------------------------------------------------------------------
    always_comb begin
        w_wa_nxt      = r_wa;
        w_wd_nxt      = r_wd;
        w_we_nxt      = 1'b0;      // write enable lasts exactly one cycle
        w_cap_we_nxt  = r_cap_we;
        w_off_nxt     = r_off;
        w_ld_size_nxt = r_ld_size;
        w_ld_sext_nxt = r_ld_sext;

        if (w_accept) begin
            w_wa_nxt      = in_wa;
            w_cap_we_nxt  = in_we;
            w_off_nxt     = in_res[1:0];
            w_ld_size_nxt = in_ld_size;
            w_ld_sext_nxt = in_ld_sext;
            if (!in_ld) begin
                w_wd_nxt = in_res;
                w_we_nxt = in_we && (in_wa != '0);
            end
        end

        if (w_ld_done) begin
            w_wd_nxt = w_ld_data;
            w_we_nxt = r_cap_we && (r_wa != '0);
        end
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            r_wa      <= '0;
            r_wd      <= '0;
            r_we      <= 1'b0;
            r_cap_we  <= 1'b0;
            r_off     <= 2'd0;
            r_ld_size <= 2'd0;
            r_ld_sext <= 1'b0;
        end else begin
            r_wa      <= w_wa_nxt;
            r_wd      <= w_wd_nxt;
            r_we      <= w_we_nxt;
            r_cap_we  <= w_cap_we_nxt;
            r_off     <= w_off_nxt;
            r_ld_size <= w_ld_size_nxt;
            r_ld_sext <= w_ld_sext_nxt;
        end
    end

    assign wa = r_wa;
    assign wd = r_wd;
    assign we = r_we;

    // ------------------------------------------------------------------------
    // Hazard export: an outstanding load that will write, or the commit cycle
    // itself (the register file has not yet absorbed the value).
    // ------------------------------------------------------------------------
    assign pend_valid = ((r_state == S_WAIT_DATA) && r_cap_we) || r_we;
    assign pend_wa    = r_wa;

    // ------------------------------------------------------------------------
    // Optional commit trace
    // ------------------------------------------------------------------------
`ifdef WB_DEBUG_TRACE_EN
    logic [31:0] r_pc;

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            r_pc <= 32'd0;
        end else if (w_accept) begin
            r_pc <= in_pc;
        end
    end

    assign debug_wb_pc       = r_pc;
    assign debug_wb_rf_wen   = {4{r_we}};
    assign debug_wb_rf_wnum  = 5'(r_wa);
    assign debug_wb_rf_wdata = 32'(r_wd);
`else
    // The PC is only needed for the trace; fold it away otherwise.
    logic w_unused_pc;
    assign w_unused_pc = ^in_pc;
`endif

endmodule
`default_nettype wire
